// File: rtl/clk_div_pkg.sv
// clk_div_ctrl shared types and helpers.
// Controller states, ratio width and ratio legality.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOPPED,
    RUN,
    STOP_PEND
  } state_e;

  function automatic int div_w(input int max_div);
    return $clog2(max_div + 1);
  endfunction

  function automatic logic div_legal(
    input int div,
    input int max_div
  );
    return (div >= 2) && (div <= max_div);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio request handshake between config logic
// and the divider controller.
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV = 16,
  parameter int DIV_W   = div_w(MAX_DIV)
) ();

  logic [DIV_W-1:0] div_i;
  logic             div_valid_i;
  logic             div_ready_o;

  modport master (
    output div_i,
    output div_valid_i,
    input  div_ready_o
  );

  modport slave (
    input  div_i,
    input  div_valid_i,
    output div_ready_o
  );

endinterface

// File: rtl/clk_div_counter.sv
// Programmable mod-N counter with sync clear,
// enable and terminal-count output.
module clk_div_counter #(
  parameter int DIV_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_mod,
  output logic [DIV_W-1:0] o_cnt_nxt,
  output logic             o_tc
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_tc;

  assign w_tc      = (r_cnt == i_mod - DIV_W'(1));
  assign o_tc      = w_tc;
  assign o_cnt_nxt = w_cnt_nxt;

  // next count: clear wins, else wrap at terminal count
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)
      w_cnt_nxt = '0;
    else if (i_en)
      w_cnt_nxt = w_tc ? '0 : r_cnt + DIV_W'(1);
  end

  // count register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_cnt <= '0;
    else           r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider controller.
// Optional odd-ratio 50% duty: CLK_DIV_CTRL_ODD_DUTY_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV     = 16,
  parameter int DIV_W       = div_w(MAX_DIV),
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  clk_div_ctrl_if.slave    bus,
  output logic [DIV_W-1:0] div_o,
  output logic             err_o,
  output logic             tick_o,
  output logic             running_o,
  output logic             clk_o
);

  state_e           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, r_shadow, w_div_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W:0]   w_sum;
  logic             r_pend, r_err, r_pre;
  logic             w_pre_nxt, w_tc, w_bound;
  logic             w_stopped, w_run;
  logic             w_xfer, w_legal;

  assign w_stopped = (r_state == STOPPED);
  assign w_run     = !w_stopped;
  assign w_bound   = w_run & w_tc;
  assign w_xfer    = bus.div_valid_i & bus.div_ready_o;
  assign w_legal   = div_legal(int'(bus.div_i), MAX_DIV);

  assign bus.div_ready_o = !r_pend;
  assign div_o     = r_div;
  assign err_o     = r_err;
  assign tick_o    = w_bound;
  assign running_o = w_run;

  clk_div_counter #(.DIV_W(DIV_W)) u_cnt (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .i_clr     (w_stopped),
    .i_en      (w_run),
    .i_mod     (r_div),
    .o_cnt_nxt (w_cnt_nxt),
    .o_tc      (w_tc)
  );

  // run/stop sequencing, stops land on a boundary
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      STOPPED:   if (en_i) w_state_nxt = RUN;
      RUN:       if (!en_i) w_state_nxt = STOP_PEND;
      STOP_PEND: begin
        if (en_i)      w_state_nxt = RUN;
        else if (w_tc) w_state_nxt = STOPPED;
      end
      default:   w_state_nxt = STOPPED;
    endcase
  end

  // ratio in effect next cycle; a shadow left
  // over from the final boundary lands at once
  always_comb begin
    w_div_nxt = r_div;
    if (w_stopped & r_pend)
      w_div_nxt = r_shadow;
    else if (w_stopped & w_xfer & w_legal)
      w_div_nxt = bus.div_i;
    else if (w_bound & r_pend)
      w_div_nxt = r_shadow;
  end

  // high phase from ceil(div/2), registered from
  // next count so clk_o comes straight off a flop
  always_comb begin
    w_sum     = {1'b0, w_div_nxt} + {{DIV_W{1'b0}}, 1'b1};
    w_pre_nxt = (w_cnt_nxt >= w_sum[DIV_W:1]);
  end

  // controller state, ratio, shadow and pulses
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state  <= STOPPED;
      r_div    <= DIV_W'(DEFAULT_DIV);
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_err    <= 1'b0;
      r_pre    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_err   <= w_xfer & !w_legal;
      r_pre   <= w_pre_nxt;
      if (w_xfer & w_legal & w_run) begin
        r_shadow <= bus.div_i;
        r_pend   <= 1'b1;
      end else if (r_pend & (w_bound | w_stopped)) begin
        r_pend <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_CTRL_ODD_DUTY_EN
  logic r_post;

  // half-cycle extension of the high phase for odd ratios
  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni)  r_post <= 1'b0;
    else if (w_stopped) r_post <= 1'b0;
    else            r_post <= r_pre & r_div[0];
  end

  assign clk_o = r_pre | r_post;
`else
  assign clk_o = r_pre;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl.
// Table-driven cycles plus multi-cycle sequences.
module tb_clk_div_ctrl;

  localparam int MAX_DIV = 16;
  localparam int DW = 5;

  logic clk, rst_n, en;
  logic [DW-1:0] div_o;
  logic err_o, tick_o, running_o, clk_o;
  int checks = 0;
  int errors = 0;

  clk_div_ctrl_if #(.MAX_DIV(MAX_DIV)) bus ();

  clk_div_ctrl #(.MAX_DIV(MAX_DIV), .DEFAULT_DIV(5)) dut (
    .clk_i     (clk),
    .reset_ni  (rst_n),
    .en_i      (en),
    .bus       (bus),
    .div_o     (div_o),
    .err_o     (err_o),
    .tick_o    (tick_o),
    .running_o (running_o),
    .clk_o     (clk_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          vld;
    logic [DW-1:0] div;
    int            e_div;
    logic          e_rdy;
    logic          e_err;
    logic          e_run;
    logic          e_clk;
    logic          e_tick;
  } vec_t;

  vec_t vt[22];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick_o) begin
        ok = 1;
        break;
      end
    end
    chk("wait_tick", ok, 1);
  endtask

  task automatic wait_stop();
    int ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!running_o) begin
        ok = 1;
        break;
      end
    end
    chk("wait_stop", ok, 1);
  endtask

  // counts high half-cycles and ticks over n cycles
  task automatic measure(input int n, input int eh, input int et);
    int hi = 0;
    int tk = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      hi += int'(clk_o);
      @(posedge clk);
      #1;
      hi += int'(clk_o);
      tk += int'(tick_o);
    end
    chk("high_halves", hi, eh);
    chk("ticks", tk, et);
  endtask

  function automatic vec_t mk(
    input logic e, input logic v, input int d,
    input int ed, input logic rd, input logic er,
    input logic ru, input logic ck, input logic tk
  );
    vec_t t;
    t.en = e; t.vld = v; t.div = DW'(d);
    t.e_div = ed; t.e_rdy = rd; t.e_err = er;
    t.e_run = ru; t.e_clk = ck; t.e_tick = tk;
    return t;
  endfunction

  int odd_on;

  initial begin
`ifdef CLK_DIV_CTRL_ODD_DUTY_EN
    odd_on = 1;
`else
    odd_on = 0;
`endif
    //        en vld div  div rdy err run clk tick
    vt[0]  = mk(0, 1, 4,   4, 1, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 1,   4, 1, 1, 0, 0, 0);
    vt[2]  = mk(0, 1, 0,   4, 1, 1, 0, 0, 0);
    vt[3]  = mk(0, 1, 17,  4, 1, 1, 0, 0, 0);
    vt[4]  = mk(1, 0, 0,   4, 1, 0, 1, 0, 0);
    vt[5]  = mk(1, 0, 0,   4, 1, 0, 1, 0, 0);
    vt[6]  = mk(1, 1, 6,   4, 0, 0, 1, 1, 0);
    vt[7]  = mk(1, 0, 0,   4, 0, 0, 1, 1, 1);
    vt[8]  = mk(1, 0, 0,   6, 1, 0, 1, 0, 0);
    vt[9]  = mk(1, 0, 0,   6, 1, 0, 1, 0, 0);
    vt[10] = mk(1, 1, 1,   6, 1, 1, 1, 0, 0);
    vt[11] = mk(1, 1, 0,   6, 1, 1, 1, 1, 0);
    vt[12] = mk(1, 0, 0,   6, 1, 0, 1, 1, 0);
    vt[13] = mk(1, 0, 0,   6, 1, 0, 1, 1, 1);
    vt[14] = mk(0, 0, 0,   6, 1, 0, 1, 0, 0);
    vt[15] = mk(1, 0, 0,   6, 1, 0, 1, 0, 0);
    vt[16] = mk(0, 0, 0,   6, 1, 0, 1, 0, 0);
    vt[17] = mk(0, 0, 0,   6, 1, 0, 1, 1, 0);
    vt[18] = mk(0, 0, 0,   6, 1, 0, 1, 1, 0);
    vt[19] = mk(0, 0, 0,   6, 1, 0, 1, 1, 1);
    vt[20] = mk(0, 0, 0,   6, 1, 0, 0, 0, 0);
    vt[21] = mk(0, 1, 16, 16, 1, 0, 0, 0, 0);

    rst_n = 1'b0;
    en = 1'b0;
    bus.div_i = '0;
    bus.div_valid_i = 1'b0;
    #22;
    rst_n = 1'b1;

    chk("rst_div", int'(div_o), 5);
    chk("rst_ready", int'(bus.div_ready_o), 1);
    chk("rst_err", int'(err_o), 0);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_run", int'(running_o), 0);
    chk("rst_clk", int'(clk_o), 0);

    for (int i = 0; i < 22; i++) begin
      en = vt[i].en;
      bus.div_valid_i = vt[i].vld;
      bus.div_i = vt[i].div;
      step();
      chk($sformatf("v%0d_div", i), int'(div_o), vt[i].e_div);
      chk($sformatf("v%0d_rdy", i), int'(bus.div_ready_o), int'(vt[i].e_rdy));
      chk($sformatf("v%0d_err", i), int'(err_o), int'(vt[i].e_err));
      chk($sformatf("v%0d_run", i), int'(running_o), int'(vt[i].e_run));
      chk($sformatf("v%0d_clk", i), int'(clk_o), int'(vt[i].e_clk));
      chk($sformatf("v%0d_tick", i), int'(tick_o), int'(vt[i].e_tick));
    end

    // div 5 running: 2 periods
    bus.div_valid_i = 1'b1;
    bus.div_i = 5'd5;
    en = 1'b1;
    step();
    bus.div_valid_i = 1'b0;
    chk("d5_div", int'(div_o), 5);
    wait_tick();
    measure(10, odd_on ? 10 : 8, 2);
    en = 1'b0;
    wait_stop();

    // div 7 loaded while stopped
    bus.div_valid_i = 1'b1;
    bus.div_i = 5'd7;
    step();
    bus.div_valid_i = 1'b0;
    chk("d7_div", int'(div_o), 7);
    chk("d7_run", int'(running_o), 0);
    en = 1'b1;
    wait_tick();
    measure(7, odd_on ? 7 : 6, 1);
    en = 1'b0;
    wait_stop();

    // stop with pending change on the same boundary
    bus.div_valid_i = 1'b1;
    bus.div_i = 5'd8;
    step();
    bus.div_valid_i = 1'b0;
    en = 1'b1;
    step();
    bus.div_valid_i = 1'b1;
    bus.div_i = 5'd3;
    step();
    bus.div_valid_i = 1'b0;
    chk("sp_rdy", int'(bus.div_ready_o), 0);
    step();
    en = 1'b0;
    step();
    chk("sp_run3", int'(running_o), 1);
    chk("sp_clk3", int'(clk_o), 0);
    for (int k = 4; k < 8; k++) begin
      step();
      chk($sformatf("sp_clk%0d", k), int'(clk_o), 1);
      chk($sformatf("sp_tick%0d", k), int'(tick_o), int'(k == 7));
      chk($sformatf("sp_div%0d", k), int'(div_o), 8);
    end
    step();
    chk("sp_run_end", int'(running_o), 0);
    chk("sp_div_end", int'(div_o), 3);
    chk("sp_rdy_end", int'(bus.div_ready_o), 1);
    chk("sp_clk_end", int'(clk_o), 0);

    // async reset while clk_o high with a pending request
    bus.div_valid_i = 1'b1;
    bus.div_i = 5'd5;
    step();
    bus.div_valid_i = 1'b0;
    en = 1'b1;
    step();
    bus.div_valid_i = 1'b1;
    bus.div_i = 5'd9;
    step();
    bus.div_valid_i = 1'b0;
    step();
    step();
    chk("ar_clk_hi", int'(clk_o), 1);
    chk("ar_rdy_lo", int'(bus.div_ready_o), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_clk", int'(clk_o), 0);
    chk("ar_run", int'(running_o), 0);
    chk("ar_rdy", int'(bus.div_ready_o), 1);
    en = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    chk("ar_div", int'(div_o), 5);
    chk("ar_rdy2", int'(bus.div_ready_o), 1);
    chk("ar_run2", int'(running_o), 0);
    chk("ar_tick2", int'(tick_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
